// File: rtl/mips_run_ctrl.sv
// ============================================================================
// Module      : mips_run_ctrl
// Description : Run controller for single_cycle_mips_32. Downloads a program
//               into instruction memory over a valid/ready host port, runs
//               the core after a start pulse and stops it on a PC breakpoint,
//               a cycle budget or an abort, then reports cause and cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_run_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       stop_pc,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [31:0]       core_pc,
  output logic              core_rst,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CYC_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_PC     = 2'b01;
  localparam logic [1:0] CAUSE_BUDGET = 2'b10;
  localparam logic [1:0] CAUSE_ABORT  = 2'b11;

  state_t            state;
  logic              rst_cnt;
  logic [31:0]       stop_pc_q;
  logic [CYC_W-1:0]  max_q;

  logic              pc_hit;
  logic              budget_hit;
  logic              stop_req;

  // Load port is open only while the core is not executing; writes pass straight through.
  assign ld_ready   = (state == S_IDLE) || (state == S_DONE);
  assign imem_we    = ld_valid & ld_ready;
  assign imem_waddr = ld_addr;
  assign imem_wdata = ld_data;

  // Stop conditions are evaluated in the current cycle so the breakpoint instruction never executes.
  assign pc_hit     = (core_pc == stop_pc_q);
  assign budget_hit = (max_q != '0) && (cycle_count == max_q);
  assign stop_req   = abort | pc_hit | budget_hit;
  assign core_en    = (state == S_RUN) && !stop_req;

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      rst_cnt     <= 1'b0;
      stop_pc_q   <= '0;
      max_q       <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RESET;
            rst_cnt     <= 1'b0;
            stop_pc_q   <= stop_pc;
            max_q       <= max_cycles;
            core_rst    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
          end
        end
        S_RESET: begin
          if (abort) begin
            state      <= S_DONE;
            core_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            halt_cause <= CAUSE_ABORT;
          end else if (rst_cnt) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
          end else begin
            rst_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop_req) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Abort outranks a PC match, which outranks the budget.
            if (abort)       halt_cause <= CAUSE_ABORT;
            else if (pc_hit) halt_cause <= CAUSE_PC;
            else             halt_cause <= CAUSE_BUDGET;
          end else if (cycle_count != '1) begin
            // Saturate rather than wrap when running without a budget.
            cycle_count <= cycle_count + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
